// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer for the EX stage: iterative shift-add MUL and restoring DIV/REM.
// Optional MDU_FAST_MUL_EN: MUL is a single-cycle combinational product (IDLE -> DONE).
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_op_mode,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_reg_write
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]      OP_MUL  = 3'd5;
  localparam logic [2:0]      OP_DIV  = 3'd6;
  localparam logic [2:0]      OP_REM  = 3'd7;
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + ONE;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_x;   // MUL: accumulator   DIV: partial remainder
  logic [XLEN-1:0]  r_y;   // MUL: multiplicand  DIV: divisor magnitude
  logic [XLEN-1:0]  r_z;   // MUL: multiplier    DIV: dividend in / quotient out
  logic             r_neg_q;
  logic             r_neg_r;
  logic [4:0]       r_rd;
  logic             r_done;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_rd_out;

  logic            w_is_mdu;
  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;
  logic [XLEN-1:0] w_y_init;
  logic [XLEN-1:0] w_z_init;
  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_sub;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_final;

`ifdef MDU_FAST_MUL_EN
  logic [XLEN-1:0] w_fast_prod;
  assign w_fast_prod = i_rs1_data * i_rs2_data;
`endif

  assign w_is_mdu = (i_op_mode == OP_MUL) | (i_op_mode == OP_DIV) | (i_op_mode == OP_REM);
  assign w_accept = (r_state == S_IDLE) & i_valid & w_is_mdu & ~i_flush;
  assign w_a_neg  = i_rs1_data[XLEN-1];
  assign w_b_neg  = i_rs2_data[XLEN-1];
  assign w_a_mag  = w_a_neg ? negate(i_rs1_data) : i_rs1_data;
  assign w_b_mag  = w_b_neg ? negate(i_rs2_data) : i_rs2_data;
  assign w_div0   = (i_rs2_data == {XLEN{1'b0}});
  assign w_ovf    = (i_rs1_data == MIN_INT) & (i_rs2_data == {XLEN{1'b1}});

  // Accept-time operand setup and the DIV/REM short-circuit results
  always_comb begin
    w_special = {XLEN{1'b0}};
    w_y_init  = w_b_mag;
    w_z_init  = w_a_mag;
    if (i_op_mode == OP_MUL) begin
      w_y_init = i_rs1_data;
      w_z_init = i_rs2_data;
    end else begin
      w_y_init = w_b_mag;
      w_z_init = w_a_mag;
    end
    if (i_op_mode == OP_DIV) begin
      w_special = w_div0 ? {XLEN{1'b1}} : MIN_INT;
    end else begin
      w_special = w_div0 ? i_rs1_data : {XLEN{1'b0}};
    end
  end

  // One shift-add / restoring-subtract step, plus the sign fix-up applied on the final step
  always_comb begin
    w_mul_acc = r_x + (r_z[0] ? r_y : {XLEN{1'b0}});
    w_shift   = {r_x, r_z[XLEN-1]};
    w_sub     = w_shift - {1'b0, r_y};
    if (w_sub[XLEN] == 1'b0) begin
      w_rem_next = w_sub[XLEN-1:0];
      w_quo_next = {r_z[XLEN-2:0], 1'b1};
    end else begin
      w_rem_next = w_shift[XLEN-1:0];
      w_quo_next = {r_z[XLEN-2:0], 1'b0};
    end
    case (r_op)
      OP_MUL:  w_final = w_mul_acc;
      OP_DIV:  w_final = r_neg_q ? negate(w_quo_next) : w_quo_next;
      OP_REM:  w_final = r_neg_r ? negate(w_rem_next) : w_rem_next;
      default: w_final = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM with datapath and registered result/destination
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_op     <= 3'd0;
      r_x      <= {XLEN{1'b0}};
      r_y      <= {XLEN{1'b0}};
      r_z      <= {XLEN{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd     <= 5'd0;
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_rd_out <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= i_op_mode;
            r_rd    <= i_rd;
            r_cnt   <= {CNT_W{1'b0}};
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_x     <= {XLEN{1'b0}};
            r_y     <= w_y_init;
            r_z     <= w_z_init;
            if (i_op_mode == OP_MUL) begin
`ifdef MDU_FAST_MUL_EN
              r_result <= w_fast_prod;
              r_rd_out <= i_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`else
              r_state  <= S_CALC;
`endif
            end else if (w_div0 | w_ovf) begin
              r_result <= w_special;
              r_rd_out <= i_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op == OP_MUL) begin
              r_x <= w_mul_acc;
              r_y <= r_y << 1;
              r_z <= r_z >> 1;
            end else begin
              r_x <= w_rem_next;
              r_z <= w_quo_next;
            end
            if (r_cnt == LAST_ITER) begin
              r_result <= w_final;
              r_rd_out <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing on the DONE cycle kills the writeback pulse
  assign o_done      = r_done & ~i_flush;
  assign o_reg_write = o_done;
  assign o_result    = r_result;
  assign o_rd        = r_rd_out;
  assign o_ready     = (r_state == S_IDLE);
  assign o_stall     = i_valid & w_is_mdu & ~o_done & ~i_flush;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed literal cases plus randomized traffic against a
// transaction-level reference (result from signed arithmetic, completion from a latency count).
module tb_mdu_seq;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [2:0]  i_op_mode = 3'd0;
  logic [31:0] i_rs1_data = 32'd0;
  logic [31:0] i_rs2_data = 32'd0;
  logic [4:0]  i_rd = 5'd0;
  logic        i_flush = 1'b0;
  logic        o_ready, o_stall, o_done, o_reg_write;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  int checks = 0;
  int errors = 0;

  // reference state: cycles left until the done cycle, and the results
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = 32'd0, out_res = 32'd0;
  logic [4:0]  m_rd = 5'd0, out_rd = 5'd0;
  bit          ev_abort, ev_leave;

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op_mode(i_op_mode),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd(i_rd), .i_flush(i_flush),
    .o_ready(o_ready), .o_stall(o_stall), .o_done(o_done), .o_result(o_result),
    .o_rd(o_rd), .o_reg_write(o_reg_write)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mdu(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (op == 3'd5) r = a * b;
    else if (b == 32'd0) r = (op == 3'd6) ? 32'hFFFF_FFFF : a;
    else if (a == MIN_INT && b == 32'hFFFF_FFFF) r = (op == 3'd6) ? MIN_INT : 32'd0;
    else if (op == 3'd6) r = $signed(a) / $signed(b);
    else r = $signed(a) % $signed(b);
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd5) return MUL_LAT;
    if (b == 32'd0 || (a == MIN_INT && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic model_reset();
    m_left = 0; m_done = 1'b0; out_res = 32'd0; out_rd = 5'd0;
  endtask

  // advance the reference across one rising edge, using the inputs held across it
  task automatic model_edge();
    ev_abort = 1'b0; ev_leave = 1'b0;
    if (i_rst) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0; ev_leave = 1'b1;
    end else if (m_left > 0) begin
      if (i_flush) begin
        m_left = 0; ev_abort = 1'b1;
      end else begin
        m_left--;
        if (m_left == 0) begin m_done = 1'b1; out_res = m_res; out_rd = m_rd; end
      end
    end else if (i_valid && is_mdu(i_op_mode) && !i_flush) begin
      m_res  = ref_calc(i_op_mode, i_rs1_data, i_rs2_data);
      m_rd   = i_rd;
      m_left = ref_lat(i_op_mode, i_rs1_data, i_rs2_data) - 1;
      if (m_left == 0) begin m_done = 1'b1; out_res = m_res; out_rd = m_rd; end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  // per-cycle comparison against the reference, away from the active edge
  always @(negedge i_clk) begin
    logic e_done;
    e_done = m_done & ~i_flush;
    chk("done", {31'd0, o_done}, {31'd0, e_done});
    chk("reg_write", {31'd0, o_reg_write}, {31'd0, e_done});
    chk("ready", {31'd0, o_ready}, {31'd0, (m_left == 0 && !m_done)});
    chk("stall", {31'd0, o_stall}, {31'd0, i_valid & is_mdu(i_op_mode) & ~e_done & ~i_flush});
    chk("result", o_result, out_res);
    chk("rd", {27'd0, o_rd}, {27'd0, out_rd});
  end

  // present one op to an idle unit and measure it from the DUT side
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int stall_cnt);
    bit got;
    i_valid = 1'b1; i_op_mode = op; i_rs1_data = a; i_rs2_data = b; i_rd = rd; i_flush = 1'b0;
    got = 1'b0; lat = 0; stall_cnt = 0; res = 32'd0; rdo = 5'd0;
    #1;
    if (o_stall) stall_cnt++;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (o_done) begin got = 1'b1; lat = c; res = o_result; rdo = o_rd; end
      else if (o_stall) stall_cnt++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout op=%0d a=%h b=%h no o_done within 40 cycles", op, a, b);
    end
    tick();
    i_valid = 1'b0;
    tick();
  endtask

  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat, scnt;

  initial begin
    model_reset();
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_result", o_result, 32'd0);

    run_op(3'd5, 32'd7, 32'hFFFF_FFFD, 5'd3, res, rdo, lat, scnt);
    chk("mul_res", res, 32'hFFFF_FFEB);
    chk("mul_rd", {27'd0, rdo}, 32'd3);
    chk("mul_lat", lat, MUL_LAT);
    chk("mul_stall_cycles", scnt, MUL_LAT);

    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd4, res, rdo, lat, scnt);
    chk("div_neg_res", res, 32'hFFFF_FFFA);
    chk("div_neg_lat", lat, 33);
    run_op(3'd7, 32'hFFFF_FFEC, 32'd3, 5'd5, res, rdo, lat, scnt);
    chk("rem_neg_res", res, 32'hFFFF_FFFE);
    chk("rem_neg_lat", lat, 33);

    run_op(3'd6, 32'd5, 32'd0, 5'd6, res, rdo, lat, scnt);
    chk("div0_res", res, 32'hFFFF_FFFF);
    chk("div0_lat", lat, 1);
    run_op(3'd7, 32'd5, 32'd0, 5'd7, res, rdo, lat, scnt);
    chk("rem0_res", res, 32'd5);
    chk("rem0_lat", lat, 1);

    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, 5'd8, res, rdo, lat, scnt);
    chk("divovf_res", res, MIN_INT);
    chk("divovf_lat", lat, 1);
    run_op(3'd7, MIN_INT, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, scnt);
    chk("removf_res", res, 32'd0);
    chk("removf_lat", lat, 1);

    // flush a MUL at CALC cycle 10
    i_valid = 1'b1; i_op_mode = 3'd5; i_rs1_data = 32'd9; i_rs2_data = 32'd11; i_rd = 5'd10;
    tick();
    for (int c = 1; c < 10; c++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_nodone", {31'd0, o_done}, 32'd0);
    tick();
    run_op(3'd6, 32'd100, 32'd7, 5'd11, res, rdo, lat, scnt);
    chk("div_after_flush", res, 32'd14);
    chk("div_after_flush_rd", {27'd0, rdo}, 32'd11);

    // async reset mid-CALC, valid dropped after accept
    i_valid = 1'b1; i_op_mode = 3'd6; i_rs1_data = 32'd1000; i_rs2_data = 32'd3; i_rd = 5'd12;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    chk("arst_ready", {31'd0, o_ready}, 32'd1);
    chk("arst_stall", {31'd0, o_stall}, 32'd0);
    chk("arst_result", o_result, 32'd0);
    tick();
    i_rst = 1'b0;
    tick();
    run_op(3'd5, 32'd3, 32'd4, 5'd13, res, rdo, lat, scnt);
    chk("mul_after_rst", res, 32'd12);

    // randomized pipeline traffic: random ops, operands, flushes and valid drops
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          fin;
      int          sel;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? MIN_INT : (sel < 3) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel < 4) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      i_valid = 1'b1; i_op_mode = op; i_rs1_data = a; i_rs2_data = b; i_rd = 5'($urandom_range(0, 31));
      fin = 1'b0;
      for (int c = 0; c < 60 && !fin; c++) begin
        i_flush = ($urandom_range(0, 49) == 0);
        if (m_left > 0) i_valid = ($urandom_range(0, 5) != 0);
        tick();
        if (!is_mdu(op) || ev_abort || ev_leave) fin = 1'b1;
      end
      if (!fin) begin
        checks++; errors++;
        $display("FAIL rand_timeout op=%0d a=%h b=%h not retired within 60 cycles", op, a, b);
      end
      i_flush = 1'b0;
    end

    i_valid = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage.
- Accepts instructions the decoder marks with op_mode 5 (MUL), 6 (DIV) or 7 (REM), and runs an iterative shift-add multiplier or restoring divider.
- Stalls the pipeline while busy, then returns the result with its destination register for writeback.
- Sits beside the ALU; the pipeline muxes its result in when o_done is high.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  EX stage holds a valid instruction.
- i_op_mode  in  3  decoder op_mode; 5=MUL, 6=DIV, 7=REM, others ignored.
- i_rs1_data  in  XLEN  operand A (multiplicand / dividend).
- i_rs2_data  in  XLEN  operand B (multiplier / divisor).
- i_rd  in  5  destination register.
- i_flush  in  1  kill in-flight operation (branch/ecall redirect).
- o_ready  out  1  state==IDLE.
- o_stall  out  1  hold IF/ID/EX registers.
- o_done  out  1  one-cycle result-valid pulse.
- o_result  out  XLEN  result, registered.
- o_rd  out  5  destination captured at accept.
- o_reg_write  out  1  equals o_done.

Behaviour:
- Reset (async, i_rst=1): state IDLE, counter 0, all internal registers 0; o_done=0, o_result=0, o_rd=0, o_reg_write=0, o_ready=1, o_stall=0.
- FSM states: IDLE, CALC, DONE.
- Accept: in IDLE with i_valid=1, i_op_mode in {5,6,7} and i_flush=0. Latch op, operands, i_rd; counter=0.
  - MUL → CALC.
  - DIV/REM with divisor 0 or overflow (A=0x80000000, B=0xFFFFFFFF) → DONE directly.
  - Other DIV/REM → CALC.
- CALC: one iteration per cycle, counter++; after XLEN iterations (counter==XLEN-1 on the final cycle) → DONE.
  - MUL: shift-add on raw bit patterns; result = low XLEN bits of A*B (the low word is sign-agnostic).
  - DIV/REM: divide the magnitudes |A| and |B| with restoring division. Negate the quotient if sign(A)!=sign(B). Remainder takes the sign of A. Sign fix-up happens on the DONE transition.
- DONE: o_done=1 and o_reg_write=1 for exactly one cycle; o_result and o_rd are valid. Next state is always IDLE.
- Special results:
  - DIV by 0 → all ones.
  - REM by 0 → A.
  - DIV overflow → 0x80000000.
  - REM overflow → 0.
- Latency, counted from the accept edge:
  - Normal: o_done high in cycle XLEN+1 (33).
  - Special cases: cycle 1.
- o_stall = i_valid & (i_op_mode in {5,6,7}) & ~o_done & ~i_flush.
  - The pipeline advances on the DONE edge, so the same instruction is never re-accepted.
  - An op presented in IDLE stalls combinationally in the accept cycle.
- o_ready = (state==IDLE). Non-MDU ops in IDLE: no state change, o_stall=0.
- o_result and o_rd hold their value until the next DONE; they are not cleared on return to IDLE.
- i_flush in CALC or DONE: next state IDLE, o_done suppressed that cycle, o_result unchanged. A flush in IDLE blocks accept.
- i_valid dropping mid-CALC: ignored; the operation completes (only i_flush aborts).
- Async reset mid-CALC: immediate return to reset values; no o_done is ever produced for the aborted op.
- Counter never wraps; CNT_W bounds it.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL computes the full product in one cycle combinationally and goes IDLE→DONE, so o_done arrives in cycle 1. DIV/REM are unchanged.
- Undefined: MUL is iterative with XLEN+1 latency as above; no multiplier is inferred.

Test Plan:
- MUL A=7, B=0xFFFFFFFD → o_result 0xFFFFFFEB, o_rd=i_rd, o_done exactly cycle 33 after accept (cycle 1 with MDU_FAST_MUL_EN); o_stall high cycles 0..32.
- DIV A=0xFFFFFFEC (-20), B=3 → 0xFFFFFFFA. REM same operands → 0xFFFFFFFE. Each takes 33 cycles.
- DIV A=5, B=0 → 0xFFFFFFFF. REM A=5, B=0 → 5. Both have o_done in cycle 1 and never enter CALC.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM same operands → 0. Both have o_done in cycle 1.
- MUL accepted, i_flush pulsed at CALC cycle 10 → no o_done, o_ready=1 next cycle, a following DIV 100/7 is accepted and returns 14.
- Async i_rst asserted mid-CALC between clock edges → o_ready=1, o_stall=0, o_result=0 immediately. After release, MUL 3*4 returns 12.
